// File: rtl/min_second_min_sequencer.sv
// Two-pass min / second-min sequencer for one check-node processor.
// Define MSM_WATCHDOG_EN to add a per-pass watchdog with a sticky FAULT state.
module min_second_min_sequencer #(
  parameter int N_INPUTS       = 40,
  parameter int WATCHDOG_LIMIT = 48,
  parameter int WD_W           = 7
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic start_i,
  input  logic result_ack_i,
  input  logic done_iterations_i,
  output logic busy_o,
  output logic result_valid_o,
  output logic initialize_min_o,
  output logic initialize_second_min_o,
  output logic reset_count_o,
  output logic calculating_second_min_o,
  output logic load_first_min_o,
  output logic load_second_min_o,
  output logic fault_o
);

  typedef enum logic [2:0] {
    IDLE,
    INIT1,
    PASS1,
    INIT2,
    PASS2,
    DONE
`ifdef MSM_WATCHDOG_EN
    , FAULT
`endif
  } state_t;

  localparam bit PARAMS_OK = (WATCHDOG_LIMIT > N_INPUTS + 1) &&
                             ((64'd1 << WD_W) > 64'(WATCHDOG_LIMIT));

  state_t state_q, state_d;

`ifdef MSM_WATCHDOG_EN
  logic [WD_W-1:0] wd_q, wd_d;
  logic            wd_trip;

  // Counter restarts in each INIT state, so it measures cycles spent in the following pass.
  always_comb begin
    wd_d = wd_q;
    if (state_q == INIT1 || state_q == INIT2) begin
      wd_d = '0;
    end else if (state_q == PASS1 || state_q == PASS2) begin
      wd_d = wd_q + 1'b1;
    end
  end

  assign wd_trip = (wd_q == WD_W'(WATCHDOG_LIMIT - 1)) && !done_iterations_i;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d                  = state_q;
    busy_o                   = 1'b1;
    result_valid_o           = 1'b0;
    initialize_min_o         = 1'b0;
    initialize_second_min_o  = 1'b0;
    reset_count_o            = 1'b0;
    calculating_second_min_o = 1'b0;
    load_first_min_o         = 1'b0;
    load_second_min_o        = 1'b0;
    fault_o                  = 1'b0;

    case (state_q)
      IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          state_d = INIT1;
        end
      end

      INIT1: begin
        initialize_min_o = 1'b1;
        reset_count_o    = 1'b1;
        state_d          = PASS1;
      end

      // Loads are gated by done so the out-of-range mux slot is never captured.
      PASS1: begin
        load_first_min_o = !done_iterations_i;
        if (done_iterations_i) begin
          state_d = INIT2;
        end
`ifdef MSM_WATCHDOG_EN
        else if (wd_trip) begin
          state_d = FAULT;
        end
`endif
      end

      INIT2: begin
        initialize_second_min_o  = 1'b1;
        reset_count_o            = 1'b1;
        calculating_second_min_o = 1'b1;
        state_d                  = PASS2;
      end

      PASS2: begin
        calculating_second_min_o = 1'b1;
        load_second_min_o        = !done_iterations_i;
        if (done_iterations_i) begin
          state_d = DONE;
        end
`ifdef MSM_WATCHDOG_EN
        else if (wd_trip) begin
          state_d = FAULT;
        end
`endif
      end

      // Ack together with start chains straight into the next computation.
      DONE: begin
        result_valid_o = 1'b1;
        if (result_ack_i) begin
          state_d = start_i ? INIT1 : IDLE;
        end
      end

`ifdef MSM_WATCHDOG_EN
      FAULT: begin
        fault_o = 1'b1;
      end
`endif

      default: begin
        busy_o  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assert property (@(posedge clk_i) PARAMS_OK);

  assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(load_first_min_o && load_second_min_o));

  assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !((initialize_min_o || initialize_second_min_o) &&
      (load_first_min_o || load_second_min_o)));

  assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(done_iterations_i && (load_first_min_o || load_second_min_o)));

endmodule

// File: tb/tb_min_second_min_sequencer.sv
// Scoreboard bench for min_second_min_sequencer; done_iterations comes from a counter model.
// Covers the MSM_WATCHDOG_EN fault path when that macro is defined.
module tb_min_second_min_sequencer;

  localparam int N_INPUTS       = 40;
  localparam int WATCHDOG_LIMIT = 48;
  localparam int WD_W           = 7;

  logic clk_i = 1'b0;
  logic reset_n_i;
  logic start_i;
  logic result_ack_i;
  logic done_iterations_i;
  logic busy_o, result_valid_o, initialize_min_o, initialize_second_min_o;
  logic reset_count_o, calculating_second_min_o, load_first_min_o;
  logic load_second_min_o, fault_o;

  int   checks     = 0;
  int   failures   = 0;
  int   violations = 0;
  int   count      = 0;
  int   lim1       = N_INPUTS;
  int   lim2       = N_INPUTS;
  logic forceLow   = 1'b0;

  typedef struct {
    int l1;
    int l2;
    int lat;
  } exp_t;
  exp_t expq[$];

  always #5 clk_i = ~clk_i;

  min_second_min_sequencer #(
    .N_INPUTS(N_INPUTS), .WATCHDOG_LIMIT(WATCHDOG_LIMIT), .WD_W(WD_W)
  ) dut (
    .clk_i(clk_i),
    .reset_n_i(reset_n_i),
    .start_i(start_i),
    .result_ack_i(result_ack_i),
    .done_iterations_i(done_iterations_i),
    .busy_o(busy_o),
    .result_valid_o(result_valid_o),
    .initialize_min_o(initialize_min_o),
    .initialize_second_min_o(initialize_second_min_o),
    .reset_count_o(reset_count_o),
    .calculating_second_min_o(calculating_second_min_o),
    .load_first_min_o(load_first_min_o),
    .load_second_min_o(load_second_min_o),
    .fault_o(fault_o)
  );

  // Behavioural datapath counter; per-pass limits let directed vectors vary pass length.
  always @(posedge clk_i) begin
    if (reset_count_o) count <= 0;
    else if (count < 1000) count <= count + 1;
  end

  assign done_iterations_i = !forceLow &&
                             (count >= (calculating_second_min_o ? lim2 : lim1));

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int outVec();
    logic [8:0] v;
    v = {busy_o, result_valid_o, initialize_min_o, initialize_second_min_o, reset_count_o,
         calculating_second_min_o, load_first_min_o, load_second_min_o, fault_o};
    return int'(v);
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic a, input logic r);
    start_i      = s;
    result_ack_i = a;
    reset_n_i    = r;
    tick();
  endtask

  task automatic waitResult(input int budget);
    int n;
    n = 0;
    while (!result_valid_o && n < budget) begin
      tick();
      n++;
    end
    checkOutput("result_timeout", int'(result_valid_o), 1);
  endtask

  // Monitor: counts loads and cycles per transaction, pops the scoreboard on result_valid rise.
  int   monL1 = 0, monL2 = 0, monCyc = 0;
  logic prevRv = 1'b0;
  always @(negedge clk_i) begin
    exp_t e;
    if (initialize_min_o) begin
      monCyc = 1;
      monL1  = 0;
      monL2  = 0;
    end else if (busy_o && !result_valid_o) begin
      monCyc++;
    end
    if (load_first_min_o)  monL1++;
    if (load_second_min_o) monL2++;

    if ((load_first_min_o && load_second_min_o) ||
        ((initialize_min_o || initialize_second_min_o) && (load_first_min_o || load_second_min_o)) ||
        ((load_first_min_o || load_second_min_o) && done_iterations_i) ||
        (!busy_o && outVec() != 0)) begin
      violations++;
      $display("[TB] invariant violation at %0t", $time);
    end
`ifndef MSM_WATCHDOG_EN
    if (fault_o) begin
      violations++;
      $display("[TB] fault raised without watchdog at %0t", $time);
    end
`endif

    if (result_valid_o && !prevRv) begin
      if (expq.size() == 0) begin
        checkOutput("unexpected_result", expq.size(), 1);
      end else begin
        e = expq.pop_front();
        checkOutput("loads_first_min", monL1, e.l1);
        checkOutput("loads_second_min", monL2, e.l2);
        checkOutput("latency", monCyc, e.lat);
      end
    end
    prevRv = result_valid_o;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    reset_n_i    = 1'b0;
    start_i      = 1'b0;
    result_ack_i = 1'b0;
    tick();

    // Reset held with start asserted
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("reset_outputs", outVec(), 0);
    reset_n_i = 1'b1;
    checkOutput("idle_after_release", int'(busy_o), 0);

    // Nominal 40/40 transaction
    lim1 = 40; lim2 = 40;
    expq.push_back('{40, 40, 84});
    tick();
    checkOutput("init1_after_start", int'({initialize_min_o, reset_count_o, busy_o}), 7);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("pass1_first_load", int'({load_first_min_o, calculating_second_min_o}), 2);
    waitResult(200);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("result_held", int'({result_valid_o, busy_o}), 3);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("ack_to_idle", outVec(), 0);

    // Start and ack pulses while busy are ignored
    lim1 = 10; lim2 = 3;
    expq.push_back('{10, 3, 17});
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("start_ignored", int'({initialize_min_o, load_first_min_o}), 1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("ack_ignored", int'({busy_o, result_valid_o}), 2);
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitResult(100);

    // Back-to-back into zero-length passes
    lim1 = 0; lim2 = 0;
    expq.push_back('{0, 0, 4});
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("b2b_init1", int'({initialize_min_o, result_valid_o, busy_o}), 5);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("zero_len_no_load", int'(load_first_min_o), 0);
    waitResult(50);

    lim1 = 1; lim2 = 1;
    expq.push_back('{1, 1, 6});
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("b2b_init1_again", int'({initialize_min_o, result_valid_o, busy_o}), 5);
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitResult(50);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("ack_only_idle", outVec(), 0);

    // Reset in the tenth PASS2 cycle abandons the computation
    lim1 = 40; lim2 = 40;
    applyStimulus(1'b1, 1'b0, 1'b1);
    start_i = 1'b0;
    for (int n = 0; n < 100 && !(calculating_second_min_o && !initialize_second_min_o); n++) tick();
    checkOutput("reach_pass2", int'(calculating_second_min_o && !initialize_second_min_o), 1);
    for (int n = 0; n < 9; n++) tick();
    checkOutput("pass2_cycle10_loading", int'(load_second_min_o), 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("midpass_reset", outVec(), 0);
    reset_n_i = 1'b1;
    for (int n = 0; n < 60; n++) tick();
    checkOutput("no_result_after_reset", int'({busy_o, result_valid_o}), 0);

    lim1 = 2; lim2 = 2;
    expq.push_back('{2, 2, 8});
    applyStimulus(1'b1, 1'b0, 1'b1);
    start_i = 1'b0;
    waitResult(50);
    applyStimulus(1'b0, 1'b1, 1'b1);
    result_ack_i = 1'b0;

`ifdef MSM_WATCHDOG_EN
    // done never arrives: trip after 48 PASS1 cycles, sticky until reset
    forceLow = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b1);
    start_i = 1'b0;
    for (int n = 0; n < 48; n++) tick();
    checkOutput("wd_pass1_cycle48", int'({load_first_min_o, fault_o}), 2);
    tick();
    checkOutput("wd_fault", outVec(), 9'h101);
    forceLow = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("wd_fault_sticky", outVec(), 9'h101);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("wd_reset_clears", outVec(), 0);
    reset_n_i = 1'b1;
`else
    // Without the watchdog a pass waits for done as long as it takes
    forceLow = 1'b1;
    lim1 = 40; lim2 = 2;
    expq.push_back('{59, 2, 65});
    applyStimulus(1'b1, 1'b0, 1'b1);
    start_i = 1'b0;
    for (int n = 0; n < 60; n++) tick();
    checkOutput("long_pass_waiting", int'({load_first_min_o, fault_o, busy_o}), 5);
    forceLow = 1'b0;
    waitResult(50);
    applyStimulus(1'b0, 1'b1, 1'b1);
    result_ack_i = 1'b0;
`endif

    tick();
    tick();
    checkOutput("pending_expected", expq.size(), 0);
    checkOutput("invariants", violations, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
